// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sram_arbiter
// Brief   : Two-requester (instruction/data) arbiter for a single-port SRAM
//           with a one-cycle read latency; data wins, with an optional
//           anti-starvation streak limit (macro SRAM_ARBITER_FAIRNESS_EN).
// Revision: 1.0 - initial release
// ============================================================================
module sram_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    inst_req,
  input  logic [ADDR_WIDTH-1:0]   inst_addr,
  output logic                    inst_ready,
  output logic                    inst_rvalid,
  output logic [DATA_WIDTH-1:0]   inst_rdata,
  input  logic                    data_req,
  input  logic [DATA_WIDTH/8-1:0] data_wstrb,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  output logic                    data_ready,
  output logic                    data_rvalid,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic                    ram_en,
  output logic [DATA_WIDTH/8-1:0] ram_wstrb,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  localparam int c_STRB_W = DATA_WIDTH / 8;

  // Encoding is {valid, owner}: owner 0 = inst, 1 = data.
  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_INST_PEND = 2'b10,
    S_DATA_PEND = 2'b11
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_inst_rdata;
  logic [DATA_WIDTH-1:0] r_data_rdata;
  logic                  w_inst_grant;
  logic                  w_data_grant;

`ifdef SRAM_ARBITER_FAIRNESS_EN
  localparam int c_STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_DATA_STREAK);

  logic [c_STREAK_W-1:0] r_streak;
  logic                  w_inst_turn;

  assign w_inst_turn  = (r_streak == c_STREAK_MAX);
  assign w_data_grant = !reset && data_req && !(inst_req && w_inst_turn);

  // Counts data wins only while inst is actually waiting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_streak <= '0;
    end else if (!inst_req || w_inst_grant) begin
      r_streak <= '0;
    end else if (w_data_grant && (r_streak != c_STREAK_MAX)) begin
      r_streak <= r_streak + c_STREAK_W'(1);
    end
  end
`else
  assign w_data_grant = !reset && data_req;
`endif

  assign w_inst_grant = !reset && inst_req && !w_data_grant;

  assign inst_ready = w_inst_grant;
  assign data_ready = w_data_grant;

  assign ram_en    = w_inst_grant || w_data_grant;
  assign ram_wstrb = w_data_grant ? data_wstrb : {c_STRB_W{1'b0}};
  assign ram_addr  = w_data_grant ? data_addr : inst_addr;
  assign ram_wdata = data_wdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      if (r_state == S_INST_PEND) r_inst_rdata <= ram_rdata;
      if (r_state == S_DATA_PEND) r_data_rdata <= ram_rdata;
      if (w_inst_grant)      r_state <= S_INST_PEND;
      else if (w_data_grant) r_state <= S_DATA_PEND;
      else                   r_state <= S_IDLE;
    end
  end

  // Response cycle passes RAM data straight through; otherwise hold last value.
  assign inst_rvalid = (r_state == S_INST_PEND);
  assign data_rvalid = (r_state == S_DATA_PEND);
  assign inst_rdata  = inst_rvalid ? ram_rdata : r_inst_rdata;
  assign data_rdata  = data_rvalid ? ram_rdata : r_data_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_arbiter
// Brief   : Scoreboard bench for sram_arbiter (default or fairness build).
// Revision: 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

  localparam int          c_AW  = 32;
  localparam int          c_DW  = 32;
  localparam int          c_SW  = 4;
  localparam logic [31:0] c_PAT = 32'hA5A5_5A5A;

  logic            clock = 1'b0;
  logic            reset;
  logic            inst_req, inst_ready, inst_rvalid;
  logic [c_AW-1:0] inst_addr;
  logic [c_DW-1:0] inst_rdata;
  logic            data_req, data_ready, data_rvalid;
  logic [c_SW-1:0] data_wstrb;
  logic [c_AW-1:0] data_addr;
  logic [c_DW-1:0] data_wdata, data_rdata;
  logic            ram_en;
  logic [c_SW-1:0] ram_wstrb;
  logic [c_AW-1:0] ram_addr;
  logic [c_DW-1:0] ram_wdata;
  logic [c_DW-1:0] ram_rdata = '0;

  sram_arbiter #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .MAX_DATA_STREAK(4)) dut (
    .clock(clock), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ready(inst_ready),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ready(data_ready),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .ram_en(ram_en), .ram_wstrb(ram_wstrb), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  // RAM stand-in: one-cycle latency, data is an address-derived pattern.
  always @(posedge clock) if (ram_en) ram_rdata <= ram_addr ^ c_PAT;

  typedef struct { int kind; logic [31:0] data; } resp_t;
  resp_t       q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_i = '0;
  logic [31:0] last_d = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called 1 time unit after a rising edge; g = expected grant (0 none, 1 inst, 2 data).
  task automatic cyc(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                     input logic [3:0] wstrb, input logic [31:0] daddr,
                     input logic [31:0] wdata, input int g);
    resp_t r;
    inst_req = ireq; inst_addr = iaddr; data_req = dreq;
    data_wstrb = wstrb; data_addr = daddr; data_wdata = wdata;
    @(negedge clock);
    check("inst_ready", inst_ready, g == 1);
    check("data_ready", data_ready, g == 2);
    check("ram_en", ram_en, g != 0);
    if (g == 1) begin
      check("ram_addr_i", ram_addr, iaddr);
      check("ram_wstrb_i", ram_wstrb, 4'h0);
    end else if (g == 2) begin
      check("ram_addr_d", ram_addr, daddr);
      check("ram_wstrb_d", ram_wstrb, wstrb);
      check("ram_wdata", ram_wdata, wdata);
    end else begin
      check("ram_wstrb_0", ram_wstrb, 4'h0);
    end
    r.kind = 0; r.data = '0;
    if (q.size() > 0) r = q.pop_front();
    check("inst_rvalid", inst_rvalid, r.kind == 1);
    check("data_rvalid", data_rvalid, r.kind == 2);
    if (r.kind == 1) last_i = r.data;
    if (r.kind == 2) last_d = r.data;
    check("inst_rdata", inst_rdata, last_i);
    check("data_rdata", data_rdata, last_d);
    r.kind = g;
    r.data = ((g == 1) ? iaddr : daddr) ^ c_PAT;
    q.push_back(r);
    @(posedge clock); #1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 0);
  endtask

  // Both requesters held for six cycles.
  task automatic contend(input logic [31:0] base);
`ifdef SRAM_ARBITER_FAIRNESS_EN
    int exp_g[6] = '{2, 2, 2, 2, 1, 2};
`else
    int exp_g[6] = '{2, 2, 2, 2, 2, 2};
`endif
    for (int i = 0; i < 6; i++)
      cyc(1'b1, base + 32'(i * 4), 1'b1, 4'h0, base + 32'h1000 + 32'(i * 4), 32'h0, exp_g[i]);
    idle();
  endtask

  initial begin
    reset = 1'b1;
    inst_req = 1'b1; inst_addr = 32'h10; data_req = 1'b1;
    data_wstrb = 4'hF; data_addr = 32'h20; data_wdata = 32'h1234;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_inst_ready", inst_ready, 1'b0);
    check("rst_data_ready", data_ready, 1'b0);
    check("rst_ram_en", ram_en, 1'b0);
    check("rst_inst_rvalid", inst_rvalid, 1'b0);
    check("rst_data_rvalid", data_rvalid, 1'b0);
    check("rst_inst_rdata", inst_rdata, 32'h0);
    check("rst_data_rdata", data_rdata, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle();

    // Lone instruction fetch from the boot vector.
    cyc(1'b1, 32'hBFC0_0000, 1'b0, 4'h0, 32'h0, 32'h0, 1);
    idle();
    // Contention with a full-word write: data wins.
    cyc(1'b1, 32'hBFC0_0004, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF, 2);
    idle();
    // Lone data accesses: read and partial write.
    cyc(1'b0, 32'h0, 1'b1, 4'h0, 32'h300, 32'h0, 2);
    cyc(1'b0, 32'h0, 1'b1, 4'h3, 32'h304, 32'hCAFE_F00D, 2);
    idle();

    contend(32'h4000);

    // Alternating single grants back to back.
    cyc(1'b1, 32'h500, 1'b0, 4'h0, 32'h0, 32'h0, 1);
    cyc(1'b0, 32'h0, 1'b1, 4'h0, 32'h600, 32'h0, 2);
    cyc(1'b1, 32'h504, 1'b0, 4'h0, 32'h0, 32'h0, 1);
    idle();

    // Reset right after a data read grant (streak already 1 in fairness build).
    cyc(1'b1, 32'h700, 1'b1, 4'h0, 32'h200, 32'h0, 2);
    reset = 1'b1;
    @(negedge clock);
    check("flush_data_rvalid", data_rvalid, 1'b0);
    check("flush_inst_rvalid", inst_rvalid, 1'b0);
    check("flush_data_rdata", data_rdata, 32'h0);
    check("flush_ram_en", ram_en, 1'b0);
    q.delete();
    last_i = '0; last_d = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    inst_req = 1'b0; data_req = 1'b0;
    idle();
    idle();
    contend(32'h8000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
